// File: rtl/instruction_decode_pkg.sv
// rtl/instruction_decode_pkg.sv - shared opcodes, ALU codes, FSM states and decoded bundle type
package instruction_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    // M-extension ops occupy 16..23, indexed by funct3
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_size;
        logic [2:0]  branch_type;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
    } bundle_t;

endpackage

// File: rtl/instruction_decode_imm_gen.sv
// rtl/instruction_decode_imm_gen.sv - combinational RV32I immediate former
module instruction_decode_imm_gen
    import instruction_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // select immediate format from the opcode; bit 31 always provides the sign
    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - registered RV32I decode stage; DECODE_M_EXT_EN enables M-extension decode
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int instr_size = 32,
    parameter int cnt_width  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [instr_size-1:0] instr_in,
    input  logic [instr_size-1:0] pc_in,
    input  logic                  instr_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [instr_size-1:0] pc_out,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [31:0]           imm,
    output logic [4:0]            alu_op,
    output logic                  alu_src_imm,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [2:0]            mem_size,
    output logic [2:0]            branch_type,
    output logic                  is_branch,
    output logic                  is_jal,
    output logic                  is_jalr,
    output logic                  illegal,
    output logic [cnt_width-1:0]  decode_count
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_w;
    bundle_t     dec;
    logic        legal;
    logic        writes_rd;

    state_e                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [instr_size-1:0]  pc_q, pc_d;
    bundle_t                bundle_q, bundle_d;
    logic [cnt_width-1:0]   count_q, count_d;
    logic                   accept;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];

    instruction_decode_imm_gen u_imm_gen (
        .instr (instr_in[31:0]),
        .imm   (imm_w)
    );

    // a new word is taken only when running and neither flushed nor stalled
    assign accept = instr_valid && !flush && !stall && (state_q == ST_RUN);

    // decode the incoming word into a bundle and a legality flag
    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        dec.rd    = instr_in[11:7];
        dec.rs1   = instr_in[19:15];
        dec.rs2   = instr_in[24:20];
        dec.imm   = imm_w;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                case (f7)
                    7'b0000000: begin
                        legal = 1'b1;
                        case (f3)
                            3'd0:    dec.alu_op = ALU_ADD;
                            3'd1:    dec.alu_op = ALU_SLL;
                            3'd2:    dec.alu_op = ALU_SLT;
                            3'd3:    dec.alu_op = ALU_SLTU;
                            3'd4:    dec.alu_op = ALU_XOR;
                            3'd5:    dec.alu_op = ALU_SRL;
                            3'd6:    dec.alu_op = ALU_OR;
                            default: dec.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        legal      = (f3 == 3'd0) || (f3 == 3'd5);
                        dec.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                    end
                    7'b0000001: begin
`ifdef DECODE_M_EXT_EN
                        legal      = 1'b1;
                        dec.alu_op = ALU_MUL | {2'b00, f3};
`else
                        legal      = 1'b0;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                writes_rd       = 1'b1;
                dec.alu_src_imm = 1'b1;
                legal           = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = ALU_ADD;
                    3'd1: begin
                        dec.alu_op = ALU_SLL;
                        legal      = (f7 == 7'b0000000);
                    end
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: begin
                        dec.alu_op = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        legal      = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                    3'd6:    dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                legal           = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                writes_rd       = 1'b1;
                dec.mem_read    = 1'b1;
                dec.mem_size    = f3;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
            end
            OPC_STORE: begin
                legal           = (f3 <= 3'd2);
                dec.rd          = 5'd0;
                dec.mem_write   = 1'b1;
                dec.mem_size    = f3;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
            end
            OPC_BRANCH: begin
                legal           = (f3 != 3'd2) && (f3 != 3'd3);
                dec.rd          = 5'd0;
                dec.is_branch   = 1'b1;
                dec.branch_type = f3;
                dec.alu_op      = ALU_SUB;
            end
            OPC_JAL: begin
                legal      = 1'b1;
                writes_rd  = 1'b1;
                dec.is_jal = 1'b1;
                dec.alu_op = ALU_ADD;
            end
            OPC_JALR: begin
                legal           = (f3 == 3'd0);
                writes_rd       = 1'b1;
                dec.is_jalr     = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
            end
            OPC_LUI: begin
                legal           = 1'b1;
                writes_rd       = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_PASSB;
            end
            OPC_AUIPC: begin
                legal           = 1'b1;
                writes_rd       = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_ADD;
            end
            OPC_FENCE: begin
                // ordering is trivially satisfied in this in-order pipe: a plain NOP
                legal = 1'b1;
            end
            default: legal = 1'b0;  // SYSTEM (ECALL/EBREAK) and unknown opcodes
        endcase
        dec.reg_write = writes_rd && (dec.rd != 5'd0);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // FSM next state: an accepted illegal word halts until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && !legal) state_d = ST_HALT;
    end

    // FSM outputs
    always_comb begin
        illegal   = (state_q == ST_HALT);
        out_valid = out_valid_q && (state_q == ST_RUN);
    end

    // stage register next values: flush beats stall beats load
    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        bundle_d    = bundle_q;
        count_d     = count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (stall) begin
            out_valid_d = out_valid_q;
        end else if (state_q == ST_HALT) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = instr_valid && legal;
            if (instr_valid && legal) begin
                pc_d     = pc_in;
                bundle_d = dec;
                count_d  = count_q + 1'b1;
            end
        end
    end

    // stage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            bundle_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            bundle_q    <= bundle_d;
            count_q     <= count_d;
        end
    end

    assign pc_out       = pc_q;
    assign rd           = bundle_q.rd;
    assign rs1          = bundle_q.rs1;
    assign rs2          = bundle_q.rs2;
    assign imm          = bundle_q.imm;
    assign alu_op       = bundle_q.alu_op;
    assign alu_src_imm  = bundle_q.alu_src_imm;
    assign reg_write    = bundle_q.reg_write;
    assign mem_read     = bundle_q.mem_read;
    assign mem_write    = bundle_q.mem_write;
    assign mem_size     = bundle_q.mem_size;
    assign branch_type  = bundle_q.branch_type;
    assign is_branch    = bundle_q.is_branch;
    assign is_jal       = bundle_q.is_jal;
    assign is_jalr      = bundle_q.is_jalr;
    assign decode_count = count_q;

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed self-checking bench for instruction_decode
module tb_instruction_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write;
    logic [2:0]  mem_size, branch_type;
    logic        is_branch, is_jal, is_jalr, illegal;
    logic [31:0] decode_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    instruction_decode #(.instr_size(32), .cnt_width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .pc_out       (pc_out),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .branch_type  (branch_type),
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .illegal      (illegal),
        .decode_count (decode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic v);
        instr_in    = w;
        pc_in       = pc;
        instr_valid = v;
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        stall = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_count", decode_count, 32'd0);
        chk("reset_illegal", illegal, 1'b0);
        rst = 1'b1;

        drive(32'h00500093, 32'h10, 1'b1);
        tick();
        exp_cnt = 1;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_rd", rd, 5'd1);
        chk("addi_rs1", rs1, 5'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_alu_op", alu_op, 5'd0);
        chk("addi_src_imm", alu_src_imm, 1'b1);
        chk("addi_reg_write", reg_write, 1'b1);
        chk("addi_pc", pc_out, 32'h10);
        chk("addi_count", decode_count, 32'(exp_cnt));

        drive(32'hFE000EE3, 32'h14, 1'b1);
        tick();
        exp_cnt = 2;
        chk("beq_is_branch", is_branch, 1'b1);
        chk("beq_type", branch_type, 3'd0);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_rd", rd, 5'd0);
        chk("beq_reg_write", reg_write, 1'b0);
        chk("beq_count", decode_count, 32'(exp_cnt));

        drive(32'h00500093, 32'h18, 1'b1);
        tick();
        exp_cnt = 3;
        stall = 1'b1;
        drive(32'h00A00113, 32'h1C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_rd", rd, 5'd1);
            chk("stall_imm", imm, 32'd5);
            chk("stall_pc", pc_out, 32'h18);
            chk("stall_count", decode_count, 32'(exp_cnt));
        end
        flush = 1'b1;
        tick();
        chk("stall_flush_valid", out_valid, 1'b0);
        chk("stall_flush_count", decode_count, 32'(exp_cnt));
        stall = 1'b0;
        flush = 1'b0;

        drive(32'h00A00113, 32'h1C, 1'b0);
        tick();
        chk("idle_valid", out_valid, 1'b0);
        drive(32'h00A00113, 32'h1C, 1'b1);
        tick();
        exp_cnt = 4;
        chk("addi2_rd", rd, 5'd2);
        chk("addi2_imm", imm, 32'd10);
        chk("addi2_count", decode_count, 32'(exp_cnt));

        drive(32'h0020A423, 32'h20, 1'b1);
        tick();
        exp_cnt = 5;
        chk("sw_mem_write", mem_write, 1'b1);
        chk("sw_rd", rd, 5'd0);
        chk("sw_imm", imm, 32'd8);
        chk("sw_size", mem_size, 3'd2);
        chk("sw_rs2", rs2, 5'd2);
        chk("sw_reg_write", reg_write, 1'b0);

        drive(32'h123452B7, 32'h24, 1'b1);
        tick();
        exp_cnt = 6;
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_alu_op", alu_op, 5'd10);
        chk("lui_rd", rd, 5'd5);
        chk("lui_count", decode_count, 32'(exp_cnt));

        drive(32'hFFFFFFFF, 32'h28, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_illegal_flag", illegal, 1'b0);
        chk("flush_illegal_valid", out_valid, 1'b0);
        chk("flush_illegal_count", decode_count, 32'(exp_cnt));

        drive(32'h022081B3, 32'h2C, 1'b1);
        tick();
`ifdef DECODE_M_EXT_EN
        exp_cnt = 7;
        chk("mul_alu_op", alu_op, 5'd16);
        chk("mul_rd", rd, 5'd3);
        chk("mul_reg_write", reg_write, 1'b1);
        chk("mul_illegal", illegal, 1'b0);
`else
        chk("mul_illegal", illegal, 1'b1);
        chk("mul_valid", out_valid, 1'b0);
`endif
        chk("mul_count", decode_count, 32'(exp_cnt));

        drive(32'hFFFFFFFF, 32'h30, 1'b1);
        tick();
        chk("ill_flag", illegal, 1'b1);
        chk("ill_valid", out_valid, 1'b0);
        drive(32'h00500093, 32'h34, 1'b1);
        tick();
        chk("halt_valid", out_valid, 1'b0);
        chk("halt_illegal", illegal, 1'b1);
        chk("halt_count", decode_count, 32'(exp_cnt));
        tick();
        chk("halt_count2", decode_count, 32'(exp_cnt));

        rst = 1'b0;
        #1;
        chk("rst_illegal_clear", illegal, 1'b0);
        tick();
        rst = 1'b1;
        drive(32'h00500093, 32'h40, 1'b1);
        tick();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_count", decode_count, 32'd1);
        chk("post_rst_pc", pc_out, 32'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_count", decode_count, 32'd0);
        chk("async_illegal", illegal, 1'b0);
        chk("async_rd", rd, 5'd0);
        chk("async_pc", pc_out, 32'd0);
        tick();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
